uart2ahb_master: RTL and testbench

- UART-driven AHB initiator, used as a debug and boot loader.
- Consumes a byte stream from the uart receive side and decodes read/write command frames.
- Issues single AHB transfers as bus master to any slave, including the uart_top-style peripherals.
- Returns status and read data as bytes to the uart transmit side. Sits between the uart core byte interface and the AHB interconnect master port.

---
 rtl/uart2ahb_master.sv | 162 ++++++++++++++++
 tb/tb_uart2ahb_master.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart2ahb_master.sv
// UART byte-stream to AHB single-transfer initiator.
// Decodes 'W'/'R' frames, runs one bus transfer, replies with status/data.
module uart2ahb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [7:0]        rx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] haddr,
  output logic [DATA_W-1:0] hwdata,
  output logic              hwrite,
  output logic              hsel,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata
);

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, BUS, RESP, TXDATA
  } state_t;

  localparam logic [7:0] C_W  = 8'h57;
  localparam logic [7:0] C_R  = 8'h52;
  localparam logic [7:0] C_OK = 8'h4B;
  localparam logic [7:0] C_ER = 8'h45;
  localparam logic [7:0] C_BD = 8'h3F;
  localparam logic [15:0] T_LAST = 16'(TIMEOUT - 1);

  state_t            state;
  logic              op_wr;
  logic [1:0]        cnt;
  logic [15:0]       wcnt;
  logic [DATA_W-1:0] rdata;
  logic              rx_hs;
  logic              tx_hs;

  assign rx_hs = rx_valid && rx_ready;
  assign tx_hs = tx_valid && tx_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rx_ready <= 1'b1;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      hsel     <= 1'b0;
      hwrite   <= 1'b0;
      haddr    <= '0;
      hwdata   <= '0;
      op_wr    <= 1'b0;
      cnt      <= '0;
      wcnt     <= '0;
      rdata    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rx_hs) begin
            if (rx_data == C_W || rx_data == C_R) begin
              op_wr <= (rx_data == C_W);
              cnt   <= '0;
              state <= ADDR;
            end else begin
              op_wr    <= 1'b0;
              rx_ready <= 1'b0;
              tx_valid <= 1'b1;
              tx_data  <= C_BD;
              state    <= RESP;
            end
          end
        end
        ADDR: begin
          if (rx_hs) begin
            haddr <= {haddr[ADDR_W-9:0], rx_data};
            cnt   <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              if (op_wr) begin
                state <= WDATA;
              end else begin
                rx_ready <= 1'b0;
                hsel     <= 1'b1;
                hwrite   <= 1'b0;
                wcnt     <= '0;
                state    <= BUS;
              end
            end
          end
        end
        WDATA: begin
          if (rx_hs) begin
            hwdata <= {hwdata[DATA_W-9:0], rx_data};
            cnt    <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              rx_ready <= 1'b0;
              hsel     <= 1'b1;
              hwrite   <= 1'b1;
              wcnt     <= '0;
              state    <= BUS;
            end
          end
        end
        BUS: begin
          if (hready) begin
            hsel     <= 1'b0;
            tx_valid <= 1'b1;
            state    <= RESP;
            if (hresp) begin
              tx_data <= C_ER;
            end else begin
              tx_data <= C_OK;
              if (!hwrite) rdata <= hrdata;
            end
          end else if (wcnt == T_LAST) begin
            hsel     <= 1'b0;
            tx_valid <= 1'b1;
            tx_data  <= C_ER;
            state    <= RESP;
          end else begin
            wcnt <= wcnt + 16'd1;
          end
        end
        RESP: begin
          if (tx_hs) begin
            if (!op_wr && tx_data == C_OK) begin
              cnt     <= '0;
              tx_data <= rdata[DATA_W-1 -: 8];
              rdata   <= rdata << 8;
              state   <= TXDATA;
            end else begin
              tx_valid <= 1'b0;
              rx_ready <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        TXDATA: begin
          if (tx_hs) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              tx_valid <= 1'b0;
              rx_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              tx_data <= rdata[DATA_W-1 -: 8];
              rdata   <= rdata << 8;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart2ahb_master.sv
// Scoreboard bench for uart2ahb_master: queued expectations for
// AHB transfers and tx bytes, checked by independent monitors.
module tb_uart2ahb_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  rx_data = '0;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hwrite;
  logic        hsel;
  logic        hready = 1'b0;
  logic        hresp = 1'b0;
  logic [31:0] hrdata = '0;

  always #5 clk = ~clk;

  uart2ahb_master #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rstn(rstn),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite), .hsel(hsel),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          cyc;
  } ahb_t;

  ahb_t       ahb_q[$];
  logic [7:0] tx_q[$];

  int          s_delay = 0;
  bit          s_err = 0;
  bit          s_never = 0;
  logic [31:0] s_rdata = '0;
  int          bus_cyc = 0;

  always @(posedge clk) begin
    #1;
    if (hsel) bus_cyc++;
    else bus_cyc = 0;
    hready = hsel && !s_never && (bus_cyc > s_delay);
    hresp  = hready && s_err;
    hrdata = hready ? s_rdata : 32'h0;
  end

  ahb_t cur;
  int   cyc = 0;
  bit   prev = 0;
  bit   inprog = 0;

  always @(posedge clk) begin
    #1;
    if (!rstn) begin
      prev   = 0;
      inprog = 0;
    end else begin
      if (hsel && !prev) begin
        cyc = 1;
        if (ahb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL hsel_unexpected: got hsel=1 want 0");
        end else begin
          cur = ahb_q.pop_front();
          inprog = 1;
          check("haddr", haddr, cur.addr);
          check("hwrite", 32'(hwrite), 32'(cur.wr));
          check("hwdata", hwdata, cur.wdata);
        end
      end else if (hsel) begin
        cyc++;
        if (inprog) begin
          check("haddr_hold", haddr, cur.addr);
          check("hwdata_hold", hwdata, cur.wdata);
          check("hwrite_hold", 32'(hwrite), 32'(cur.wr));
        end
      end else if (prev && inprog) begin
        check("hsel_cycles", 32'(cyc), 32'(cur.cyc));
        inprog = 0;
      end
      prev = hsel;
    end
  end

  logic [7:0] held;
  logic [7:0] exp_b;
  bit         holding = 0;
  int         tx_hs_n = 0;
  int         stall_at = -1;
  int         stall = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      holding = 0;
    end else begin
      if (holding && tx_valid) check("tx_stable", 32'(tx_data), 32'(held));
      holding = 0;
      if (tx_valid && tx_ready) begin
        tx_hs_n++;
        if (tx_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_extra: got %0h want none", tx_data);
        end else begin
          exp_b = tx_q.pop_front();
          check("tx_byte", 32'(tx_data), 32'(exp_b));
        end
        if (tx_hs_n == stall_at) stall = 5;
      end else if (tx_valid) begin
        holding = 1;
        held = tx_data;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (stall > 0) begin
      tx_ready = 1'b0;
      stall--;
    end else begin
      tx_ready = 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!rx_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (t >= 100) begin
      total++;
      bad++;
      $display("FAIL rx_accept: got rx_ready=0 want 1");
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [31:0] a,
                       input logic [31:0] d, input int gap);
    send_byte(cmd, gap);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], gap);
    if (cmd == 8'h57)
      for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], gap);
    check("hsel_latency", 32'(hsel), 32'd1);
    check("rx_ready_bus", 32'(rx_ready), 32'd0);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((tx_q.size() != 0 || ahb_q.size() != 0 || inprog ||
            tx_valid || hsel) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("done_in_time", 32'(t < 300), 32'd1);
    check("rx_ready_idle", 32'(rx_ready), 32'd1);
    check("tx_q_drained", 32'(tx_q.size()), 32'd0);
  endtask

  task automatic push_ahb(input logic [31:0] a, input logic w,
                          input logic [31:0] d, input int c);
    ahb_t e;
    e.addr = a;
    e.wr = w;
    e.wdata = d;
    e.cyc = c;
    ahb_q.push_back(e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_hsel", 32'(hsel), 32'd0);
    check("rst_hwrite", 32'(hwrite), 32'd0);
    check("rst_haddr", haddr, 32'd0);
    check("rst_hwdata", hwdata, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    s_delay = 3;
    push_ahb(32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 4);
    tx_q.push_back(8'h4B);
    frame(8'h57, 32'h1000_0004, 32'hDEAD_BEEF, 0);
    wait_done();
    check("haddr_kept", haddr, 32'h1000_0004);
    check("hwdata_kept", hwdata, 32'hDEAD_BEEF);

    s_delay = 1;
    s_rdata = 32'h1234_5678;
    push_ahb(32'h1000_0008, 1'b0, 32'hDEAD_BEEF, 2);
    tx_q.push_back(8'h4B);
    tx_q.push_back(8'h12);
    tx_q.push_back(8'h34);
    tx_q.push_back(8'h56);
    tx_q.push_back(8'h78);
    frame(8'h52, 32'h1000_0008, 32'h0, 0);
    wait_done();

    s_delay = 0;
    s_err = 1;
    push_ahb(32'h0000_0020, 1'b0, 32'hDEAD_BEEF, 1);
    tx_q.push_back(8'h45);
    frame(8'h52, 32'h0000_0020, 32'h0, 0);
    wait_done();

    s_err = 0;
    s_never = 1;
    push_ahb(32'h0000_0024, 1'b0, 32'hDEAD_BEEF, 8);
    tx_q.push_back(8'h45);
    frame(8'h52, 32'h0000_0024, 32'h0, 0);
    wait_done();

    s_never = 0;
    tx_q.push_back(8'h3F);
    send_byte(8'h41, 0);
    wait_done();
    s_rdata = 32'hA5A5_0001;
    push_ahb(32'h0000_0030, 1'b0, 32'hDEAD_BEEF, 1);
    tx_q.push_back(8'h4B);
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h01);
    frame(8'h52, 32'h0000_0030, 32'h0, 0);
    wait_done();

    s_delay = 2;
    s_rdata = 32'h1234_5678;
    stall_at = tx_hs_n + 2;
    push_ahb(32'h0000_0040, 1'b0, 32'hDEAD_BEEF, 3);
    tx_q.push_back(8'h4B);
    tx_q.push_back(8'h12);
    tx_q.push_back(8'h34);
    tx_q.push_back(8'h56);
    tx_q.push_back(8'h78);
    frame(8'h52, 32'h0000_0040, 32'h0, 2);
    wait_done();

    s_delay = 0;
    push_ahb(32'h0000_0050, 1'b1, 32'h0102_0304, 1);
    tx_q.push_back(8'h4B);
    frame(8'h57, 32'h0000_0050, 32'h0102_0304, 3);
    wait_done();

    s_never = 1;
    push_ahb(32'h0000_0060, 1'b0, 32'h0102_0304, 0);
    frame(8'h52, 32'h0000_0060, 32'h0, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_mid_hsel", 32'(hsel), 32'd0);
    check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    s_never = 0;
    @(posedge clk);
    #1;
    check("rst_rel_rx_ready", 32'(rx_ready), 32'd1);
    s_delay = 1;
    push_ahb(32'h0000_0070, 1'b1, 32'hCAFE_F00D, 2);
    tx_q.push_back(8'h4B);
    frame(8'h57, 32'h0000_0070, 32'hCAFE_F00D, 0);
    wait_done();

    repeat (5) @(posedge clk);
    #1;
    check("ahb_q_drained", 32'(ahb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
